// File: rtl/enc424j600_reg_access.sv
// ENC424J600 SFR register access sequencer: turns one 16-bit read/write
// request into a WCRU/RCRU opcode plus three data bytes for the SPI master.
module enc424j600_reg_access #(
  parameter int TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  opbyte,
  output logic        opbyte_valid,
  output logic [10:0] nbyte_num,
  output logic [7:0]  wrdat_byte,
  output logic        wrdat_valid,
  input  logic        wrdat_ready,
  input  logic [7:0]  rddat_byte,
  input  logic        rddat_valid,
  input  logic        txn_done
);

  localparam int CW =
    ($clog2(TIMEOUT + 1) > 12) ? $clog2(TIMEOUT + 1) : 12;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, START, XFER, WAIT_DONE, RESP
  } state_t;

  state_t          state, state_nx;
  logic            wr_q;
  logic [7:0]      addr_q;
  logic [15:0]     wdata_q;
  logic [15:0]     rdata_q;
  logic [1:0]      wr_idx;
  logic [1:0]      rd_idx;
  logic [CW-1:0]   tmo_cnt;
  logic            err_q;
  logic            busy;
  logic            hs;
  logic            tmo;

  assign busy = (state == XFER) || (state == WAIT_DONE);
  assign hs   = wrdat_valid & wrdat_ready;
  assign tmo  = busy && (tmo_cnt == TO_LAST);

  assign req_ready    = (state == IDLE) && !rst;
  assign opbyte_valid = (state == START);
  assign wrdat_valid  = (state == XFER);
  assign rsp_valid    = (state == RESP);
  assign rsp_err      = (state == RESP) && err_q;
  assign nbyte_num    = 11'd3;
  assign rsp_rdata    = (state == RESP && !err_q && !wr_q)
                        ? rdata_q : 16'h0000;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (req_valid && req_ready) state_nx = START;
      START:     state_nx = XFER;
      XFER: begin
        if (txn_done || tmo)          state_nx = RESP;
        else if (hs && wr_idx == 2'd2) state_nx = WAIT_DONE;
      end
      WAIT_DONE: if (txn_done || tmo) state_nx = RESP;
      RESP:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Reads clock out two dummy bytes after the address.
  always_comb begin
    wrdat_byte = 8'h00;
    if (state == XFER) begin
      unique case (wr_idx)
        2'd0:    wrdat_byte = addr_q;
        2'd1:    wrdat_byte = wr_q ? wdata_q[7:0] : 8'h00;
        default: wrdat_byte = wr_q ? wdata_q[15:8] : 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      opbyte  <= 8'h00;
      wr_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      wr_idx  <= 2'd0;
      rd_idx  <= 2'd0;
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        opbyte  <= req_write ? 8'h22 : 8'h20;
      end
      if (state == START) begin
        tmo_cnt <= '0;
        wr_idx  <= 2'd0;
        rd_idx  <= 2'd0;
        rdata_q <= 16'h0000;
        err_q   <= 1'b0;
      end
      if (busy) tmo_cnt <= tmo_cnt + 1'b1;
      if (hs && wr_idx != 2'd3) wr_idx <= wr_idx + 2'd1;
      // First MISO byte overlaps the address and carries no data.
      if (busy && rddat_valid && rd_idx != 2'd3) begin
        rd_idx <= rd_idx + 2'd1;
        if (rd_idx == 2'd1) rdata_q[7:0]  <= rddat_byte;
        if (rd_idx == 2'd2) rdata_q[15:8] <= rddat_byte;
      end
      if (busy && state_nx == RESP) err_q <= !txn_done;
    end
  end

endmodule

// File: tb/tb_enc424j600_reg_access.sv
// Randomized bench for enc424j600_reg_access against a transaction-level
// model of the SPI master and the expected byte stream / read data.
module tb_enc424j600_reg_access;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  logic [7:0]  opbyte, wrdat_byte, rddat_byte;
  logic        opbyte_valid, wrdat_valid, wrdat_ready;
  logic        rddat_valid, txn_done;
  logic [10:0] nbyte_num;

  logic        t_req_valid, t_req_ready, t_req_write;
  logic [7:0]  t_req_addr;
  logic [15:0] t_req_wdata;
  logic        t_rsp_valid, t_rsp_err;
  logic [15:0] t_rsp_rdata;
  logic [7:0]  t_opbyte, t_wrdat_byte, t_rddat_byte;
  logic        t_opbyte_valid, t_wrdat_valid, t_wrdat_ready;
  logic        t_rddat_valid, t_txn_done;
  logic [10:0] t_nbyte_num;

  enc424j600_reg_access u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .opbyte(opbyte), .opbyte_valid(opbyte_valid),
    .nbyte_num(nbyte_num),
    .wrdat_byte(wrdat_byte), .wrdat_valid(wrdat_valid),
    .wrdat_ready(wrdat_ready),
    .rddat_byte(rddat_byte), .rddat_valid(rddat_valid),
    .txn_done(txn_done)
  );

  enc424j600_reg_access #(.TIMEOUT(16)) u_to (
    .clk(clk), .rst(rst),
    .req_valid(t_req_valid), .req_ready(t_req_ready),
    .req_write(t_req_write), .req_addr(t_req_addr),
    .req_wdata(t_req_wdata),
    .rsp_valid(t_rsp_valid), .rsp_rdata(t_rsp_rdata),
    .rsp_err(t_rsp_err),
    .opbyte(t_opbyte), .opbyte_valid(t_opbyte_valid),
    .nbyte_num(t_nbyte_num),
    .wrdat_byte(t_wrdat_byte), .wrdat_valid(t_wrdat_valid),
    .wrdat_ready(t_wrdat_ready),
    .rddat_byte(t_rddat_byte), .rddat_valid(t_rddat_valid),
    .txn_done(t_txn_done)
  );

  int n_chk = 0;
  int n_fail = 0;
  int rsp_cnt = 0;
  int exp_rsp = 0;
  int adj_cnt = 0;
  logic op_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid) rsp_cnt++;
    if (opbyte_valid && op_prev) adj_cnt++;
    op_prev = opbyte_valid;
  end

  // One complete access on u_dut; the master stops after `stop` bytes.
  task automatic txn(input bit wr, input logic [7:0] a,
                     input logic [15:0] wd, input bit thr,
                     input int stop, input bit b2b,
                     input logic [23:0] mi);
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [7:0]  miso[3];
    logic [15:0] exp_rd;
    int hs = 0, rdn = 0, cyc = 0, w = 0;
    bit pend = 0, done = 0;
    miso[0] = mi[7:0];
    miso[1] = mi[15:8];
    miso[2] = mi[23:16];
    exp_q.push_back(a);
    exp_q.push_back(wr ? wd[7:0] : 8'h00);
    exp_q.push_back(wr ? wd[15:8] : 8'h00);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait", w, b2b ? 1 : 0);
    if (w >= 20) return;
    @(negedge clk);
    if (!b2b) req_valid = 1'b0;
    chk("opv_start", 32'(opbyte_valid), 1);
    chk("opbyte", 32'(opbyte), wr ? 32'h22 : 32'h20);
    while (!done && cyc < 200) begin
      @(negedge clk);
      if (cyc == 0) chk("opv_drop", 32'(opbyte_valid), 0);
      chk("wrv", 32'(wrdat_valid), 32'(hs < 3));
      chk("rsp_early", 32'(rsp_valid), 0);
      rddat_valid = 1'b0;
      txn_done    = 1'b0;
      wrdat_ready = 1'b0;
      rddat_byte  = 8'($urandom);
      if (pend) begin
        rddat_valid = 1'b1;
        rddat_byte  = miso[rdn];
        rdn++;
        pend = 0;
      end else if (hs >= stop) begin
        txn_done = 1'b1;
        done = 1;
      end
      if (!done && hs < stop) begin
        wrdat_ready = thr ? (cyc % 8 == 7) : 1'b1;
        if (wrdat_valid && wrdat_ready) begin
          got_q.push_back(wrdat_byte);
          hs++;
          pend = 1;
        end
      end
      cyc++;
    end
    chk("xfer_bound", 32'(done), 1);
    @(negedge clk);
    rddat_valid = 1'b0;
    txn_done    = 1'b0;
    wrdat_ready = 1'b0;
    exp_rd = 16'h0000;
    if (!wr && rdn > 1) exp_rd[7:0]  = miso[1];
    if (!wr && rdn > 2) exp_rd[15:8] = miso[2];
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_err", 32'(rsp_err), 0);
    chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
    chk("opbyte_hold", 32'(opbyte), wr ? 32'h22 : 32'h20);
    chk("nbytes", got_q.size(), stop);
    foreach (got_q[i]) chk("wrdat_seq", 32'(got_q[i]), 32'(exp_q[i]));
    exp_rsp++;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    wrdat_ready = 0; rddat_byte = 0; rddat_valid = 0; txn_done = 0;
    t_req_valid = 0; t_req_write = 0; t_req_addr = 0;
    t_req_wdata = 0; t_wrdat_ready = 0; t_rddat_byte = 0;
    t_rddat_valid = 0; t_txn_done = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_opv", 32'(opbyte_valid), 0);
    chk("rst_wrv", 32'(wrdat_valid), 0);
    chk("rst_rspv", 32'(rsp_valid), 0);
    chk("rst_err", 32'(rsp_err), 0);
    chk("rst_opbyte", 32'(opbyte), 0);
    chk("rst_wrbyte", 32'(wrdat_byte), 0);
    chk("rst_rdata", 32'(rsp_rdata), 0);
    chk("rst_nbyte", 32'(nbyte_num), 3);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 1);

    // Timeout instance: no txn_done ever arrives.
    t_req_valid = 1'b1;
    t_req_addr  = 8'h20;
    @(negedge clk);
    chk("t_opv", 32'(t_opbyte_valid), 1);
    t_req_valid   = 1'b0;
    t_wrdat_ready = 1'b1;
    k = 0;
    @(negedge clk);
    while (!t_rsp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_cycles", k, 16);
    chk("tmo_err", 32'(t_rsp_err), 1);
    chk("tmo_rdata", 32'(t_rsp_rdata), 0);
    t_req_valid = 1'b1;
    @(negedge clk);
    chk("tmo_next_ready", 32'(t_req_ready), 1);
    @(negedge clk);
    chk("tmo_next_opv", 32'(t_opbyte_valid), 1);
    t_req_valid = 1'b0;
    // txn_done lands on the same cycle the timeout would fire.
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      t_rddat_valid = (c >= 1 && c <= 3);
      t_rddat_byte  = (c == 1) ? 8'hFF : (c == 2) ? 8'h34 : 8'h12;
      t_txn_done    = (c == 15);
    end
    @(negedge clk);
    t_rddat_valid = 1'b0;
    t_txn_done    = 1'b0;
    t_wrdat_ready = 1'b0;
    chk("tie_rspv", 32'(t_rsp_valid), 1);
    chk("tie_err", 32'(t_rsp_err), 0);
    chk("tie_rdata", 32'(t_rsp_rdata), 32'h1234);

    txn(1, 8'h7E, 16'hA5C3, 0, 3, 0, 24'($urandom));
    req_valid = 0; @(negedge clk);
    txn(0, 8'h40, 16'h0000, 0, 3, 0, 24'h1234FF);
    req_valid = 0; @(negedge clk);
    txn(1, 8'h13, 16'h9A5B, 1, 3, 0, 24'($urandom));
    req_valid = 0; @(negedge clk);
    txn(0, 8'h31, 16'h0000, 1, 3, 0, 24'($urandom));
    req_valid = 0; @(negedge clk);
    txn(0, 8'h52, 16'h0000, 0, 2, 0, 24'($urandom));
    txn(1, 8'h54, 16'h1111, 0, 3, 1, 24'($urandom));
    txn(0, 8'h56, 16'h0000, 0, 3, 1, 24'($urandom));

    for (int i = 0; i < 40; i++) begin
      bit b2b, thr;
      int stop;
      b2b  = ($urandom % 2) == 0;
      thr  = ($urandom % 4) == 0;
      stop = ($urandom % 5 == 0) ? int'($urandom % 3) : 3;
      if (!b2b) begin
        req_valid = 0;
        @(negedge clk);
      end
      txn($urandom % 2 == 1, 8'($urandom), 16'($urandom),
          thr, stop, b2b, 24'($urandom));
    end

    // Reset in the middle of a write.
    req_valid = 0;
    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = 8'h55; req_wdata = 16'hBEEF;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    wrdat_ready = 1;
    @(negedge clk);
    rst = 1; wrdat_ready = 0;
    @(negedge clk);
    chk("mrst_ready", 32'(req_ready), 0);
    chk("mrst_opv", 32'(opbyte_valid), 0);
    chk("mrst_wrv", 32'(wrdat_valid), 0);
    chk("mrst_rspv", 32'(rsp_valid), 0);
    chk("mrst_opbyte", 32'(opbyte), 0);
    chk("mrst_wrbyte", 32'(wrdat_byte), 0);
    rst = 0; rddat_valid = 1; txn_done = 1;
    @(negedge clk);
    rddat_valid = 0; txn_done = 0;
    chk("stale_ready", 32'(req_ready), 1);
    chk("stale_rspv", 32'(rsp_valid), 0);
    txn(0, 8'h40, 16'h0000, 0, 3, 0, 24'h12_34_FF);
    req_valid = 0;
    @(negedge clk);

    chk("rsp_count", rsp_cnt, exp_rsp);
    chk("opv_adjacent", adj_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
